// File: rtl/reg_wb_arbiter_if.sv
// Bundle of the register-file write-port arbiter signals.
// The master side drives pipeline writeback, unit returns, issue and decode
// reads. The slave side (the arbiter) returns m_ready, hazard, stall_pipe and
// the register-file write port.
interface reg_wb_arbiter_if;
    logic        p_we;
    logic [4:0]  p_addr;
    logic [31:0] p_data;
    logic        m_valid;
    logic        m_ready;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic        rd1_read;
    logic [4:0]  rd1_addr;
    logic        rd2_read;
    logic [4:0]  rd2_addr;
    logic        hazard;
    logic        stall_pipe;
    logic        we;
    logic [4:0]  write_addr;
    logic [31:0] write_data;

    modport master (
        output p_we, p_addr, p_data, m_valid, m_addr, m_data,
               iss_valid, iss_addr, rd1_read, rd1_addr, rd2_read, rd2_addr,
        input  m_ready, hazard, stall_pipe, we, write_addr, write_data
    );

    modport slave (
        input  p_we, p_addr, p_data, m_valid, m_addr, m_data,
               iss_valid, iss_addr, rd1_read, rd1_addr, rd2_read, rd2_addr,
        output m_ready, hazard, stall_pipe, we, write_addr, write_data
    );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Register-file write-port arbiter.
// The pipeline writeback has priority. Long-latency unit results are buffered
// in a small FIFO and written in free slots. A starvation counter freezes the
// pipeline for one slot so that the FIFO head is guaranteed to drain. A busy
// scoreboard tracks destinations with results still outstanding and drives the
// decode RAW hazard.
// Optional feature macro: WB_BYPASS_EN. When it is defined, a unit result that
// arrives while the FIFO is empty and the slot is free goes straight to the
// write port instead of passing through the FIFO.
module reg_wb_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic           clk,
    input  logic           rst,
    reg_wb_arbiter_if.slave bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ST_W  = $clog2(STARVE_MAX + 1);

    // Unit-result buffer storage (no reset; validity is tracked by level_reg)
    logic [4:0]  fifo_addr_mem [FIFO_DEPTH];
    logic [31:0] fifo_data_mem [FIFO_DEPTH];

    logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg;
    logic [CNT_W-1:0] level_reg;
    logic [ST_W-1:0]  starve_reg, starve_next;
    logic             stall_reg, stall_next;
    logic             we_reg, we_next;
    logic [4:0]       waddr_reg, waddr_next;
    logic [31:0]      wdata_reg, wdata_next;
    logic [31:0]      busy_reg, busy_next;

    logic        fifo_empty, fifo_full;
    logic        primary, pop, push, bypass, accept;
    logic [4:0]  head_addr;
    logic [31:0] head_data;
    logic        clr_valid;
    logic [4:0]  clr_addr;

    assign fifo_empty = (level_reg == '0);
    assign fifo_full  = (level_reg == CNT_W'(FIFO_DEPTH));
    assign head_addr  = fifo_addr_mem[rd_ptr_reg];
    assign head_data  = fifo_data_mem[rd_ptr_reg];

    // A full buffer never accepts, even on a cycle where it also pops
    assign bus.m_ready = !fifo_full && !rst;
    assign accept      = bus.m_valid && !fifo_full;

    // A write to r0 is not a write, so it leaves the slot free for the FIFO.
    // While stall_pipe is high the pipeline request is ignored.
    assign primary = bus.p_we && (bus.p_addr != 5'd0) && !stall_reg;
    assign pop     = !fifo_empty && !primary;

`ifdef WB_BYPASS_EN
    assign bypass = fifo_empty && !primary && accept;
`else
    assign bypass = 1'b0;
`endif
    assign push = accept && !bypass;

    // Select the winner for the next write-port slot and the busy bit it clears
    always_comb begin
        we_next    = 1'b0;
        waddr_next = waddr_reg;
        wdata_next = wdata_reg;
        clr_valid  = 1'b0;
        clr_addr   = 5'd0;
        if (primary) begin
            we_next    = 1'b1;
            waddr_next = bus.p_addr;
            wdata_next = bus.p_data;
        end else if (pop) begin
            we_next    = (head_addr != 5'd0);
            waddr_next = head_addr;
            wdata_next = head_data;
            clr_valid  = 1'b1;
            clr_addr   = head_addr;
        end else if (bypass) begin
            we_next    = (bus.m_addr != 5'd0);
            waddr_next = bus.m_addr;
            wdata_next = bus.m_data;
            clr_valid  = 1'b1;
            clr_addr   = bus.m_addr;
        end
    end

    // Count the cycles the head has waited; the freeze is raised one cycle
    // ahead so that the stalled slot is the one in which the head pops
    always_comb begin
        starve_next = starve_reg;
        stall_next  = 1'b0;
        if (fifo_empty || pop) begin
            starve_next = '0;
        end else begin
            if (starve_reg != ST_W'(STARVE_MAX))
                starve_next = starve_reg + ST_W'(1);
            stall_next = (starve_reg == ST_W'(STARVE_MAX - 1));
        end
    end

    // Per-register busy update. A set and a clear on the same register in
    // the same cycle leave the bit set. r0 is never busy.
    assign busy_next[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_busy
            assign busy_next[gi] =
                (bus.iss_valid && (bus.iss_addr == 5'(gi))) ? 1'b1 :
                (clr_valid && (clr_addr == 5'(gi)))         ? 1'b0 :
                busy_reg[gi];
        end
    endgenerate

    assign bus.hazard = (bus.rd1_read && busy_reg[bus.rd1_addr]) ||
                        (bus.rd2_read && busy_reg[bus.rd2_addr]);

    // Buffer write; the entry is only looked at while level_reg covers it
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_mem[wr_ptr_reg] <= bus.m_addr;
            fifo_data_mem[wr_ptr_reg] <= bus.m_data;
        end
    end

    // Buffer pointers and occupancy; the pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   level_reg <= level_reg + CNT_W'(1);
                2'b01:   level_reg <= level_reg - CNT_W'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    // Registered write port, starvation state, pipeline freeze and scoreboard
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_reg     <= 1'b0;
            waddr_reg  <= 5'd0;
            wdata_reg  <= 32'd0;
            starve_reg <= '0;
            stall_reg  <= 1'b0;
            busy_reg   <= 32'd0;
        end else begin
            we_reg     <= we_next;
            waddr_reg  <= waddr_next;
            wdata_reg  <= wdata_next;
            starve_reg <= starve_next;
            stall_reg  <= stall_next;
            busy_reg   <= busy_next;
        end
    end

    assign bus.we         = we_reg;
    assign bus.write_addr = waddr_reg;
    assign bus.write_data = wdata_reg;
    assign bus.stall_pipe = stall_reg;
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed testbench for reg_wb_arbiter with FIFO_DEPTH=2 and STARVE_MAX=4.
// Each cycle the bench drives inputs 1 time unit after the rising edge.
// Registered outputs are checked right after that edge and combinational
// outputs 1 time unit after the inputs change.
module tb_reg_wb_arbiter;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    reg_wb_arbiter_if bus();

    reg_wb_arbiter #(.FIFO_DEPTH(2), .STARVE_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Contention scenario: per-cycle pipeline address, visible write address, stall
    int c2_paddr [11] = '{1, 2, 3, 4, 5, 6, 6, 7, 8, 0, 0};
    int c2_wa    [11] = '{0, 1, 2, 3, 4, 5, 9, 6, 7, 8, 0};
    int c2_st    [11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    // Full-FIFO scenario: adds the unit address held until accepted and m_ready
    int c3_paddr [11] = '{1, 2, 3, 4, 5, 6, 6, 0, 0, 0, 0};
    int c3_maddr [11] = '{10, 11, 12, 12, 12, 12, 12, 0, 0, 0, 0};
    int c3_wa    [11] = '{0, 1, 2, 3, 4, 5, 10, 6, 11, 12, 0};
    int c3_st    [11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    int c3_rdy   [11] = '{1, 1, 0, 0, 0, 0, 1, 0, 1, 1, 1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input string tag, input bit exp_we, input int exp_addr, input logic [31:0] exp_data);
        check({tag, ".we"}, 32'(bus.we), 32'(exp_we));
        if (exp_we) begin
            check({tag, ".addr"}, 32'(bus.write_addr), 32'(exp_addr));
            check({tag, ".data"}, bus.write_data, exp_data);
        end
        $display("txn %s: we=%0d addr=%0d data=0x%0h", tag, bus.we, bus.write_addr, bus.write_data);
    endtask

    function automatic logic [31:0] data_of(input int a);
        return (a >= 9) ? 32'hA00 + 32'(a) : 32'h100 + 32'(a);
    endfunction

    task automatic idle_inputs();
        bus.p_we = 0; bus.p_addr = 0; bus.p_data = 0;
        bus.m_valid = 0; bus.m_addr = 0; bus.m_data = 0;
        bus.iss_valid = 0; bus.iss_addr = 0;
        bus.rd1_read = 0; bus.rd1_addr = 0; bus.rd2_read = 0; bus.rd2_addr = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle_inputs();
        rst = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst.we", 32'(bus.we), 0);
        check("rst.addr", 32'(bus.write_addr), 0);
        check("rst.data", bus.write_data, 0);
        check("rst.stall", 32'(bus.stall_pipe), 0);
        check("rst.m_ready", 32'(bus.m_ready), 0);
        rst = 1'b0;
        #1;
        check("rel.m_ready", 32'(bus.m_ready), 1);
        check("rel.hazard", 32'(bus.hazard), 0);

        // Idle unit return: issue r5 at N, result at N+3
        tick();
        bus.iss_valid = 1; bus.iss_addr = 5; bus.rd1_read = 1; bus.rd1_addr = 5;
        #1 check("idle.N.hazard", 32'(bus.hazard), 0);
        tick();
        bus.iss_valid = 0;
        #1 check("idle.N1.hazard", 32'(bus.hazard), 1);
        tick();
        #1 check("idle.N2.hazard", 32'(bus.hazard), 1);
        tick();
        bus.m_valid = 1; bus.m_addr = 5; bus.m_data = 32'h1234;
        #1;
        check("idle.N3.m_ready", 32'(bus.m_ready), 1);
        check("idle.N3.hazard", 32'(bus.hazard), 1);
        tick();
        check_wr("idle.N4", BYP, 5, 32'h1234);
        bus.m_valid = 0;
        #1 check("idle.N4.hazard", 32'(bus.hazard), 32'(!BYP));
        tick();
        check_wr("idle.N5", !BYP, 5, 32'h1234);
        #1 check("idle.N5.hazard", 32'(bus.hazard), 0);
        tick();
        check_wr("idle.N6", 0, 0, 0);
        bus.rd1_read = 0;
        #1;

        // Contention: pipeline writes every cycle, unit result r9 must not starve
        for (int c = 0; c < 11; c++) begin
            tick();
            check_wr($sformatf("cont.c%0d", c), c2_wa[c] != 0, c2_wa[c], data_of(c2_wa[c]));
            check($sformatf("cont.c%0d.stall", c), 32'(bus.stall_pipe), 32'(c2_st[c]));
            bus.p_we    = (c2_paddr[c] != 0);
            bus.p_addr  = 5'(c2_paddr[c]);
            bus.p_data  = data_of(c2_paddr[c]);
            bus.m_valid = (c == 0);
            bus.m_addr  = 5'd9;
            bus.m_data  = data_of(9);
            #1;
        end

        // Full FIFO: three unit results while the pipeline is busy
        for (int c = 0; c < 11; c++) begin
            tick();
            check_wr($sformatf("full.c%0d", c), c3_wa[c] != 0, c3_wa[c], data_of(c3_wa[c]));
            check($sformatf("full.c%0d.stall", c), 32'(bus.stall_pipe), 32'(c3_st[c]));
            bus.p_we    = (c3_paddr[c] != 0);
            bus.p_addr  = 5'(c3_paddr[c]);
            bus.p_data  = data_of(c3_paddr[c]);
            bus.m_valid = (c3_maddr[c] != 0);
            bus.m_addr  = 5'(c3_maddr[c]);
            bus.m_data  = data_of(c3_maddr[c]);
            #1 check($sformatf("full.c%0d.m_ready", c), 32'(bus.m_ready), 32'(c3_rdy[c]));
        end

        // Zero register: p_we r0 leaves the slot to FIFO head r3; r0 never busy
        tick();
        check_wr("zero.E0", 0, 0, 0);
        bus.p_we = 1; bus.p_addr = 1; bus.p_data = 32'h101;
        bus.m_valid = 1; bus.m_addr = 3; bus.m_data = 32'h333;
        #1;
        tick();
        check_wr("zero.E1", 1, 1, 32'h101);
        bus.p_we = 1; bus.p_addr = 0; bus.p_data = 32'hDEAD;
        bus.m_valid = 0;
        #1;
        tick();
        check_wr("zero.E2", 1, 3, 32'h333);
        bus.p_we = 0;
        bus.m_valid = 1; bus.m_addr = 0; bus.m_data = 32'hBEEF;
        bus.iss_valid = 1; bus.iss_addr = 0;
        bus.rd1_read = 1; bus.rd1_addr = 0;
        #1 check("zero.E2.hazard", 32'(bus.hazard), 0);
        tick();
        check_wr("zero.E3", 0, 0, 0);
        bus.m_valid = 0; bus.iss_valid = 0;
        #1 check("zero.E3.hazard", 32'(bus.hazard), 0);
        tick();
        check_wr("zero.E4", 0, 0, 0);
        bus.rd1_read = 0;
        #1;

        // Set/clear collision on r7: re-issue wins over the returning write
        tick();
        bus.iss_valid = 1; bus.iss_addr = 7;
        bus.p_we = 1; bus.p_addr = 1; bus.p_data = 32'h101;
        bus.m_valid = 1; bus.m_addr = 7; bus.m_data = 32'h777;
        bus.rd1_read = 1; bus.rd1_addr = 7;
        #1 check("coll.F0.hazard", 32'(bus.hazard), 0);
        tick();
        check_wr("coll.F1", 1, 1, 32'h101);
        bus.p_we = 0; bus.m_valid = 0;
        #1 check("coll.F1.hazard", 32'(bus.hazard), 1);
        tick();
        check_wr("coll.F2", 1, 7, 32'h777);
        bus.iss_valid = 0;
        #1 check("coll.F2.hazard", 32'(bus.hazard), 1);
        tick();
        check_wr("coll.F3", 0, 0, 0);
        bus.rd1_read = 0; bus.rd2_read = 1; bus.rd2_addr = 7;
        #1 check("coll.F3.hazard2", 32'(bus.hazard), 1);
        bus.rd2_read = 0;

        // Reset mid-burst with the FIFO full
        tick();
        bus.p_we = 1; bus.p_addr = 1; bus.p_data = 32'h101;
        bus.m_valid = 1; bus.m_addr = 20; bus.m_data = 32'hA14;
        bus.iss_valid = 1; bus.iss_addr = 20;
        #1;
        tick();
        bus.p_addr = 2; bus.p_data = 32'h102;
        bus.m_addr = 21; bus.m_data = 32'hA15;
        bus.iss_valid = 0;
        #1 check("mid.G1.m_ready", 32'(bus.m_ready), 1);
        tick();
        check_wr("mid.G2", 1, 2, 32'h102);
        bus.p_addr = 3; bus.p_data = 32'h103;
        bus.m_valid = 0;
        bus.rd1_read = 1; bus.rd1_addr = 20;
        #1;
        check("mid.G2.m_ready", 32'(bus.m_ready), 0);
        check("mid.G2.hazard", 32'(bus.hazard), 1);
        rst = 1'b1;
        #1;
        check("mid.rst.we", 32'(bus.we), 0);
        check("mid.rst.addr", 32'(bus.write_addr), 0);
        check("mid.rst.data", bus.write_data, 0);
        check("mid.rst.stall", 32'(bus.stall_pipe), 0);
        check("mid.rst.m_ready", 32'(bus.m_ready), 0);
        check("mid.rst.hazard", 32'(bus.hazard), 0);
        bus.p_we = 0;
        tick();
        tick();
        check("mid.rst2.we", 32'(bus.we), 0);
        rst = 1'b0;
        #1;
        check("mid.rel.m_ready", 32'(bus.m_ready), 1);
        check("mid.rel.hazard", 32'(bus.hazard), 0);
        tick();
        check_wr("mid.H1", 0, 0, 0);
        tick();
        check_wr("mid.H2", 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
